bit_reverse_reorder: RTL

Parametrised successor of the FFT output bit-reverse stage. It accepts one FFT frame in bit-reversed order and emits it in natural order. Ping-pong banks are inferred internally. The point size is selectable per frame at run time, any power of two up to 2^LOG2_MAX. A valid/ready handshake runs on both input and output, and a bypass mode is provided. It sits between the last R22SDF butterfly stage and the downstream sample consumer.

---
 rtl/bit_reverse_reorder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bit_reverse_reorder.sv
// rtl/bit_reverse_reorder.sv - ping-pong bit-reverse to natural-order frame reorder with per-frame size
module bit_reverse_reorder #(
    parameter int DWIDTH   = 32,
    parameter int LOG2_MAX = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [3:0]        i_log2_point,
    input  logic              i_bypass,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last
);

    localparam int AW    = LOG2_MAX;
    localparam int DEPTH = 1 << LOG2_MAX;

    logic [DWIDTH-1:0] mem [2*DEPTH];

    logic [AW-1:0]     wcnt;
    logic [AW-1:0]     rcnt;
    logic              wbank;
    logic              rbank;
    logic [1:0]        full;
    logic [3:0]        bank_k [2];
    logic [1:0]        bank_byp;
    logic              rdy_en;

    logic [DWIDTH-1:0] skid_data [2];
    logic [1:0]        skid_last;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occ;

    logic [3:0]        wk;
    logic [3:0]        rk;
    logic              w_fire;
    logic              w_last;
    logic              r_issue;
    logic              r_last;
    logic              pop;
    logic [1:0]        occ_after;
    logic [AW-1:0]     raddr;

    function automatic logic [3:0] clamp_k(input logic [3:0] k);
        if (k < 4'd2) return 4'd2;
        if (k > 4'(LOG2_MAX)) return 4'(LOG2_MAX);
        return k;
    endfunction

    function automatic logic [AW-1:0] last_idx(input logic [3:0] k);
        logic [AW:0] span;
        span = ((AW+1)'(1) << k) - (AW+1)'(1);
        return span[AW-1:0];
    endfunction

    // Full-width reversal moves the k live bits to the top; shift them back down.
    function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] c, input logic [3:0] k);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = c[AW-1-i];
        return r >> (4'(LOG2_MAX) - k);
    endfunction

    assign o_ready   = rdy_en && !full[wbank];
    assign w_fire    = i_valid && o_ready;
    assign wk        = (wcnt == '0) ? clamp_k(i_log2_point) : bank_k[wbank];
    assign w_last    = (wcnt == last_idx(wk));

    assign rk        = bank_k[rbank];
    assign pop       = o_valid && i_ready;
    // Counting this cycle's pop lets a read refill the slot being drained: no bubbles.
    assign occ_after = occ - {1'b0, pop};
    assign r_issue   = full[rbank] && (occ_after < 2'd2);
    assign r_last    = (rcnt == last_idx(rk));
    assign raddr     = bank_byp[rbank] ? rcnt : bit_rev(rcnt, rk);

    assign o_valid   = (occ != 2'd0);
    assign o_data    = skid_data[rd_ptr];
    assign o_last    = o_valid && skid_last[rd_ptr];

    always_ff @(posedge clk) begin
        if (w_fire) mem[{wbank, wcnt}] <= i_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en       <= 1'b0;
            wcnt         <= '0;
            rcnt         <= '0;
            wbank        <= 1'b0;
            rbank        <= 1'b0;
            full         <= 2'b00;
            bank_k[0]    <= 4'd2;
            bank_k[1]    <= 4'd2;
            bank_byp     <= 2'b00;
            skid_data[0] <= '0;
            skid_data[1] <= '0;
            skid_last    <= 2'b00;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            occ          <= 2'd0;
        end else begin
            rdy_en <= 1'b1;
            if (w_fire) begin
                if (wcnt == '0) begin
                    bank_k[wbank]   <= wk;
                    bank_byp[wbank] <= i_bypass;
                end
                if (w_last) begin
                    wcnt  <= '0;
                    wbank <= ~wbank;
                end else begin
                    wcnt  <= wcnt + AW'(1);
                end
            end
            if (r_issue) begin
                skid_data[wr_ptr] <= mem[{rbank, raddr}];
                skid_last[wr_ptr] <= r_last;
                wr_ptr            <= ~wr_ptr;
                if (r_last) begin
                    rcnt  <= '0;
                    rbank <= ~rbank;
                end else begin
                    rcnt  <= rcnt + AW'(1);
                end
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ_after + {1'b0, r_issue};
            // A bank can only be filled while empty and freed while full, so set/clear never collide.
            for (int b = 0; b < 2; b++) begin
                if (w_fire && w_last && (wbank == 1'(b)))
                    full[b] <= 1'b1;
                else if (r_issue && r_last && (rbank == 1'(b)))
                    full[b] <= 1'b0;
            end
        end
    end

endmodule
